// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: sequential N x N matrix multiplier, valid/ready in and out, one shared MAC.
// Optional macro MATMUL_SAT_EN: saturate results to OW bits and add the sat_flag output.
module matrix_mult_seq #(
    parameter int N      = 3,
    parameter int W      = 8,
    parameter int OW     = 2*W,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [OW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
`ifdef MATMUL_SAT_EN
    output logic          sat_flag,
`endif
    output logic          busy
);
    localparam int AW  = 2*W + $clog2(N);
    localparam int IW  = $clog2(N);
    localparam int AIW = $clog2(N*N);
    localparam int BW  = $clog2(2*N*N);

    typedef enum logic [1:0] {S_LOAD, S_MAC, S_OUT} state_t;

    state_t         r_state;
    logic [BW-1:0]  r_beat;
    logic [IW-1:0]  r_i, r_j, r_k;
    logic [AW-1:0]  r_acc;
    logic [OW-1:0]  r_outData;
    logic           r_outLast;
    logic [W-1:0]   r_a [N*N];
    logic [W-1:0]   r_b [N*N];

    logic [AIW-1:0] w_wrIdx, w_aIdx, w_bIdx;
    logic [W-1:0]   w_aElem, w_bElem;
    logic [AW-1:0]  w_aExt, w_bExt, w_prod, w_sum;
    logic [OW-1:0]  w_conv;
    logic           w_lastBeat, w_lastK, w_lastElem;

    // Beats below N*N land in A, the rest in B, both row-major.
    assign w_wrIdx    = (r_beat < BW'(N*N)) ? AIW'(r_beat) : AIW'(r_beat - BW'(N*N));
    assign w_aIdx     = AIW'(r_i) * AIW'(N) + AIW'(r_k);
    assign w_bIdx     = AIW'(r_k) * AIW'(N) + AIW'(r_j);
    assign w_aElem    = r_a[w_aIdx];
    assign w_bElem    = r_b[w_bIdx];
    assign w_aExt     = {{(AW-W){(SIGNED != 0) && w_aElem[W-1]}}, w_aElem};
    assign w_bExt     = {{(AW-W){(SIGNED != 0) && w_bElem[W-1]}}, w_bElem};
    assign w_prod     = w_aExt * w_bExt;
    assign w_sum      = r_acc + w_prod;
    assign w_lastBeat = (r_beat == BW'(2*N*N-1));
    assign w_lastK    = (r_k == IW'(N-1));
    assign w_lastElem = (r_i == IW'(N-1)) && (r_j == IW'(N-1));

`ifdef MATMUL_SAT_EN
    logic w_clamped;
    logic r_sat;

    generate
        if (OW < AW) begin : g_sat
            if (SIGNED != 0) begin : g_signed
                always_comb begin
                    w_conv    = w_sum[OW-1:0];
                    w_clamped = 1'b0;
                    if (w_sum[AW-1:OW-1] != {(AW-OW+1){w_sum[AW-1]}}) begin
                        w_clamped = 1'b1;
                        w_conv    = w_sum[AW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
                    end
                end
            end else begin : g_unsigned
                always_comb begin
                    w_conv    = w_sum[OW-1:0];
                    w_clamped = 1'b0;
                    if (|w_sum[AW-1:OW]) begin
                        w_clamped = 1'b1;
                        w_conv    = '1;
                    end
                end
            end
        end else begin : g_full
            assign w_conv    = w_sum[OW-1:0];
            assign w_clamped = 1'b0;
        end
    endgenerate

    assign sat_flag = r_sat && (r_state == S_OUT);
`else
    assign w_conv = w_sum[OW-1:0];
`endif

    // Operand storage needs no reset; it is always fully rewritten before use.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            if (r_beat < BW'(N*N)) begin
                r_a[w_wrIdx] <= in_data;
            end else begin
                r_b[w_wrIdx] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_LOAD;
            r_beat    <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            r_outData <= '0;
            r_outLast <= 1'b0;
`ifdef MATMUL_SAT_EN
            r_sat     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        if (w_lastBeat) begin
                            r_beat  <= '0;
                            r_i     <= '0;
                            r_j     <= '0;
                            r_k     <= '0;
                            r_acc   <= '0;
                            r_state <= S_MAC;
                        end else begin
                            r_beat <= r_beat + BW'(1);
                        end
                    end
                end
                S_MAC: begin
                    if (w_lastK) begin
                        r_k       <= '0;
                        r_acc     <= '0;
                        r_outData <= w_conv;
                        r_outLast <= w_lastElem;
`ifdef MATMUL_SAT_EN
                        r_sat     <= w_clamped;
`endif
                        r_state   <= S_OUT;
                    end else begin
                        r_k   <= r_k + IW'(1);
                        r_acc <= w_sum;
                    end
                end
                S_OUT: begin
                    // out_data and out_last stay frozen until the sink takes them.
                    if (out_ready) begin
                        if (r_outLast) begin
                            r_i       <= '0;
                            r_j       <= '0;
                            r_outLast <= 1'b0;
                            r_state   <= S_LOAD;
                        end else begin
                            if (r_j == IW'(N-1)) begin
                                r_j <= '0;
                                r_i <= r_i + IW'(1);
                            end else begin
                                r_j <= r_j + IW'(1);
                            end
                            r_state <= S_MAC;
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign in_ready  = (r_state == S_LOAD) && !rst;
    assign out_valid = (r_state == S_OUT);
    assign out_data  = r_outData;
    assign out_last  = r_outLast;
    assign busy      = !((r_state == S_LOAD) && (r_beat == '0));

endmodule

// File: tb/tb_matrix_mult_seq.sv
// tb_matrix_mult_seq: drives three matrix_mult_seq instances (N=2 unsigned, N=2 signed, N=3 unsigned)
// and compares every output beat against a plain-arithmetic matrix product model.
module tb_matrix_mult_seq;
    localparam int W  = 8;
    localparam int OW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  inData   [3];
    logic          inValid  [3];
    logic          inReady  [3];
    logic [OW-1:0] outData  [3];
    logic          outValid [3];
    logic          outReady [3];
    logic          outLast  [3];
    logic          busy     [3];
`ifdef MATMUL_SAT_EN
    logic          satFlag  [3];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    matrix_mult_seq #(.N(2), .W(W), .OW(OW), .SIGNED(0)) dutU (
        .clk(clk), .rst(rst),
        .in_data(inData[0]), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .out_data(outData[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
        .out_last(outLast[0]),
`ifdef MATMUL_SAT_EN
        .sat_flag(satFlag[0]),
`endif
        .busy(busy[0])
    );

    matrix_mult_seq #(.N(2), .W(W), .OW(OW), .SIGNED(1)) dutS (
        .clk(clk), .rst(rst),
        .in_data(inData[1]), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .out_data(outData[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
        .out_last(outLast[1]),
`ifdef MATMUL_SAT_EN
        .sat_flag(satFlag[1]),
`endif
        .busy(busy[1])
    );

    matrix_mult_seq #(.N(3), .W(W), .OW(OW), .SIGNED(0)) dutL (
        .clk(clk), .rst(rst),
        .in_data(inData[2]), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .out_data(outData[2]), .out_valid(outValid[2]), .out_ready(outReady[2]),
        .out_last(outLast[2]),
`ifdef MATMUL_SAT_EN
        .sat_flag(satFlag[2]),
`endif
        .busy(busy[2])
    );

    function automatic int dimOf(input int sel);
        return (sel == 2) ? 3 : 2;
    endfunction

    function automatic bit sgnOf(input int sel);
        return (sel == 1);
    endfunction

    // Reference: C[r][c] = sum_k A[r][k]*B[k][c] in wide integers, then wrap or clamp to OW bits.
    function automatic logic [OW-1:0] refElem(input int n, input bit sgn, input int a[9], input int b[9],
                                              input int r, input int c, output bit clamped);
        longint s;
        s = 0;
        clamped = 1'b0;
        for (int k = 0; k < n; k++) begin
            s += longint'(a[r*n+k]) * longint'(b[k*n+c]);
        end
`ifdef MATMUL_SAT_EN
        if (!sgn && s > 65535) begin
            clamped = 1'b1;
            return 16'hFFFF;
        end
        if (sgn && s > 32767) begin
            clamped = 1'b1;
            return 16'h7FFF;
        end
        if (sgn && s < -32768) begin
            clamped = 1'b1;
            return 16'h8000;
        end
`endif
        return 16'(s);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Streams A then B; optionally keeps in_valid high presenting the next job's first beat.
    task automatic applyStimulus(input int sel, input int a[9], input int b[9],
                                 input bit holdValid, input int nextFirst);
        int n;
        int guard;
        n = dimOf(sel);
        for (int t = 0; t < 2*n*n; t++) begin
            inValid[sel] = 1'b1;
            inData[sel]  = (t < n*n) ? 8'(a[t]) : 8'(b[t-n*n]);
            guard = 0;
            while (!inReady[sel] && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) checkOutput($sformatf("in_ready_timeout[%0d]", sel), 32'(inReady[sel]), 1);
            @(negedge clk);
        end
        if (holdValid) begin
            inData[sel] = 8'(nextFirst);
        end else begin
            inValid[sel] = 1'b0;
        end
    endtask

    task automatic checkJob(input int sel, input int a[9], input int b[9], input int numElems,
                            input int stallElem, input int stallCycles, input bit checkLatency);
        int n;
        int wcnt;
        bit clamped;
        logic [OW-1:0] exp;
        n = dimOf(sel);
        for (int e = 0; e < numElems; e++) begin
            exp = refElem(n, sgnOf(sel), a, b, e / n, e % n, clamped);
            outReady[sel] = 1'b1;
            wcnt = 0;
            while (!outValid[sel] && wcnt < 100) begin
                @(negedge clk);
                wcnt++;
            end
            if (checkLatency && e == 0) checkOutput($sformatf("latency[%0d]", sel), wcnt, n);
            checkOutput($sformatf("out_valid[%0d].%0d", sel, e), 32'(outValid[sel]), 1);
            checkOutput($sformatf("out_data[%0d].%0d", sel, e), 32'(outData[sel]), 32'(exp));
            checkOutput($sformatf("out_last[%0d].%0d", sel, e), 32'(outLast[sel]), 32'(e == n*n-1));
            checkOutput($sformatf("in_ready_busy[%0d].%0d", sel, e), 32'(inReady[sel]), 0);
            checkOutput($sformatf("busy[%0d].%0d", sel, e), 32'(busy[sel]), 1);
`ifdef MATMUL_SAT_EN
            checkOutput($sformatf("sat_flag[%0d].%0d", sel, e), 32'(satFlag[sel]), 32'(clamped));
`endif
            if (e == stallElem) begin
                outReady[sel] = 1'b0;
                for (int s = 0; s < stallCycles; s++) begin
                    @(negedge clk);
                    checkOutput($sformatf("stall_data[%0d].%0d", sel, s), 32'(outData[sel]), 32'(exp));
                    checkOutput($sformatf("stall_valid[%0d].%0d", sel, s), 32'(outValid[sel]), 1);
                    checkOutput($sformatf("stall_in_ready[%0d].%0d", sel, s), 32'(inReady[sel]), 0);
                end
                outReady[sel] = 1'b1;
            end
            @(negedge clk);
        end
        if (numElems == n*n) begin
            checkOutput($sformatf("done_in_ready[%0d]", sel), 32'(inReady[sel]), 1);
            checkOutput($sformatf("done_valid[%0d]", sel), 32'(outValid[sel]), 0);
            checkOutput($sformatf("done_busy[%0d]", sel), 32'(busy[sel]), 0);
        end
    endtask

    task automatic randomMatrices(input int sel, output int a[9], output int b[9]);
        for (int i = 0; i < 9; i++) begin
            a[i] = int'($urandom_range(255, 0));
            b[i] = int'($urandom_range(255, 0));
            if (sgnOf(sel)) begin
                a[i] -= 128;
                b[i] -= 128;
            end
        end
    endtask

    initial begin
        int t1a[9], t1b[9], t2a[9], t2b[9], sa[9], sb[9], ones[9], negs[9], ra[9], rb[9];
        t1a  = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
        t1b  = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
        t2a  = '{9, 10, 11, 12, 0, 0, 0, 0, 0};
        t2b  = '{2, 0, 1, 3, 0, 0, 0, 0, 0};
        sa   = '{-1, 2, 3, -4, 0, 0, 0, 0, 0};
        sb   = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
        ones = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
        negs = '{-128, -128, -128, -128, 0, 0, 0, 0, 0};

        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            inValid[s]  = 1'b0;
            inData[s]   = '0;
            outReady[s] = 1'b1;
        end
        #2;
        for (int s = 0; s < 3; s++) begin
            checkOutput($sformatf("rst_in_ready[%0d]", s), 32'(inReady[s]), 0);
            checkOutput($sformatf("rst_out_valid[%0d]", s), 32'(outValid[s]), 0);
            checkOutput($sformatf("rst_out_last[%0d]", s), 32'(outLast[s]), 0);
            checkOutput($sformatf("rst_out_data[%0d]", s), 32'(outData[s]), 0);
            checkOutput($sformatf("rst_busy[%0d]", s), 32'(busy[s]), 0);
`ifdef MATMUL_SAT_EN
            checkOutput($sformatf("rst_sat_flag[%0d]", s), 32'(satFlag[s]), 0);
`endif
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) checkOutput($sformatf("post_rst_in_ready[%0d]", s), 32'(inReady[s]), 1);
        @(negedge clk);

        $display("[TB] basic unsigned N=2");
        applyStimulus(0, t1a, t1b, 1'b0, 0);
        checkJob(0, t1a, t1b, 4, -1, 0, 1'b1);

        $display("[TB] back-pressure on element 2");
        applyStimulus(0, t1a, t1b, 1'b0, 0);
        checkJob(0, t1a, t1b, 4, 1, 5, 1'b1);

        $display("[TB] signed N=2 identity and extreme negative");
        applyStimulus(1, sa, sb, 1'b0, 0);
        checkJob(1, sa, sb, 4, -1, 0, 1'b1);
        applyStimulus(1, negs, negs, 1'b0, 0);
        checkJob(1, negs, negs, 4, -1, 0, 1'b1);

        $display("[TB] N=3 all 255");
        applyStimulus(2, ones, ones, 1'b0, 0);
        checkJob(2, ones, ones, 9, 4, 2, 1'b1);

        $display("[TB] reset during MAC of element 3");
        applyStimulus(0, t1a, t1b, 1'b0, 0);
        checkJob(0, t1a, t1b, 2, -1, 0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 32'(outValid[0]), 0);
        checkOutput("midrst_in_ready", 32'(inReady[0]), 0);
        checkOutput("midrst_busy", 32'(busy[0]), 0);
        checkOutput("midrst_out_data", 32'(outData[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_release_in_ready", 32'(inReady[0]), 1);
        applyStimulus(0, t2a, t2b, 1'b0, 0);
        checkJob(0, t2a, t2b, 4, -1, 0, 1'b1);

        $display("[TB] back-to-back jobs with in_valid held");
        applyStimulus(0, t1a, t1b, 1'b1, t2a[0]);
        checkJob(0, t1a, t1b, 4, 2, 1, 1'b1);
        applyStimulus(0, t2a, t2b, 1'b0, 0);
        checkJob(0, t2a, t2b, 4, -1, 0, 1'b1);

        $display("[TB] randomized jobs");
        for (int rep = 0; rep < 4; rep++) begin
            for (int s = 0; s < 3; s++) begin
                randomMatrices(s, ra, rb);
                applyStimulus(s, ra, rb, 1'b0, 0);
                checkJob(s, ra, rb, dimOf(s)*dimOf(s), int'($urandom_range(dimOf(s)*dimOf(s)-1, 0)),
                         int'($urandom_range(3, 0)), 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/matrix_mult_seq.md
Name: matrix_mult_seq

Overview:
- Sequential, handshaked N x N matrix multiplier for streaming datapaths; successor to the team's combinational N x N multiplier.
- Loads A then B over a single valid/ready input stream.
- Computes each C element with one shared MAC over N cycles.
- Streams C out row-major over valid/ready with a last flag.
- Adds a signed/unsigned mode, a configurable result width and back-pressure.

Parameters:
- N, 3, matrix dimension (>=2)
- W, 8, input element width
- OW, 2*W, output element width (<= AW, where AW = 2*W + $clog2(N) is the internal accumulator width)
- SIGNED, 0, 1 = inputs and outputs are two's complement; 0 = unsigned

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  W  element: A row-major, then B row-major
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data
- out_data  out  OW  C element, row-major
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts out_data
- out_last  out  1  high with C[N-1][N-1]
- busy  out  1  high in any state other than LOAD with zero beats received

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: in_ready=0 during reset and 1 afterwards; out_valid=0, out_last=0, out_data=0, busy=0. State=LOAD, all counters 0. Reset mid-operation aborts all work; no output is produced for the aborted job.
- Beat transfer: a beat transfers on a rising edge where valid && ready. Per the handshake, in_valid/out_valid are never gated by the opposite ready.
- State LOAD:
  - in_ready=1.
  - Beats 0..N*N-1 are written to A[i][k]; beats N*N..2*N*N-1 are written to B[k][j], both row-major.
  - When the final beat is accepted, go to MAC with i=j=k=0 and acc=0.
- State MAC:
  - in_ready=0.
  - Each cycle: acc += A[i][k]*B[k][j], computed at AW bits, sign-extended when SIGNED=1.
  - k increments each cycle. On k=N-1, the final sum is registered into out_data and the state goes to OUT.
  - Latency: out_valid rises exactly N cycles after the edge that accepted the last input beat.
- State OUT:
  - out_valid=1; out_data and out_last are held stable until accepted.
  - out_last=1 only when i=j=N-1.
  - On acceptance: if last, go to LOAD with counters cleared, in_ready=1 and out_valid=0 the next cycle. Otherwise advance j (wrap to 0 and increment i) and go to MAC with acc=0.
  - Each element therefore takes N MAC cycles plus at least 1 OUT cycle.
- Width rule: AW never overflows for any inputs. The conversion from AW to OW is truncation to the low OW bits (modular wrap).
- No input is accepted while computing. A new job cannot overlap the current one.
- Stalling: out_ready held low holds OUT indefinitely with no state change.
- Back-to-back jobs: only the beats of the following job are accepted, starting the cycle after the last output is accepted.

Optional Feature:
- Macro: MATMUL_SAT_EN.
- Defined: the AW-to-OW conversion saturates instead of truncating.
  - Unsigned: results above 2^OW-1 become 2^OW-1.
  - Signed: results clamp to [-2^(OW-1), 2^(OW-1)-1].
  - An extra output port, sat_flag (out, 1), is high alongside out_valid for any element that was clamped, and is 0 at reset.
- Not defined: truncation only, and the sat_flag port does not exist.

Test Plan:
- N=2, W=8, unsigned; A=[[1,2],[3,4]], B=[[5,6],[7,8]], out_ready=1 -> out_data sequence 19, 22, 43, 50; out_last only on 50; first out_valid exactly 2 cycles after the last input beat.
- N=2, SIGNED=1; A=[[-1,2],[3,-4]], B=identity -> outputs -1, 2, 3, -4 as 16-bit two's complement (0xFFFF, 0x0002, 0x0003, 0xFFFC).
- N=3, W=8, OW=16, all elements 255 -> every C = 195075; without macro out_data=64003 (0xFA03); with MATMUL_SAT_EN out_data=65535 and sat_flag=1.
- Back-pressure: in test 1, hold out_ready=0 for 5 cycles on element 2 -> out_data=22 stable, out_valid stays 1, in_ready stays 0; sequence resumes correctly with no loss or duplication.
- Reset mid-MAC: in test 1, assert rst during MAC of element 3 -> out_valid=0 immediately, then in_ready=1 after release; a fresh job produces correct results.
- Two back-to-back jobs with in_valid held high -> in_ready is low from the acceptance of job 1's last input beat until the cycle after its last output; job 2 results are correct.
